// File: rtl/router_port_rx_pkg.sv
// Purpose: shared types and constants for the router output-port receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_port_rx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    // One assembled byte plus its packet-boundary tags.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              sop;
        logic              eop;
    } rx_entry_t;

endpackage

// File: rtl/router_port_rx_if.sv
// Purpose: serial input stream from one router output port plus the byte-stream output side.
// Latency: n/a (signal bundle only).
// Backpressure: out_ready from the consumer stalls the byte stream; the serial side cannot be stalled.
// Modports: master = router/stimulus side (drives serial bits and out_ready),
//           slave  = receiver side (drives the byte stream and status).
interface router_port_rx_if #(
    parameter int LEN_W = 16
);
    import router_port_rx_pkg::*;

    logic              dout;
    logic              valido_n;
    logic              frameo_n;
    logic [BYTE_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_valid;
    logic              out_ready;
    logic              pkt_err;
    logic              ovf;
    logic [LEN_W-1:0]  pkt_len;

    modport master (
        output dout, valido_n, frameo_n, out_ready,
        input  out_data, out_sop, out_eop, out_valid, pkt_err, ovf, pkt_len
    );

    modport slave (
        input  dout, valido_n, frameo_n, out_ready,
        output out_data, out_sop, out_eop, out_valid, pkt_err, ovf, pkt_len
    );

endinterface

// File: rtl/router_port_rx_fifo.sv
// Purpose: small synchronous FIFO of rx_entry_t with fall-through head.
// Latency: a write at edge N is visible on rd_dat_o right after edge N when empty.
// Backpressure: wr_rdy_o low when full unless the head is popped on the same edge.
// Ports: clock/reset_n (async active-low), wr_vld_i/wr_rdy_o/wr_dat_i, rd_vld_o/rd_rdy_i/rd_dat_o.
module router_port_rx_fifo
    import router_port_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      wr_vld_i,
    output logic      wr_rdy_o,
    input  rx_entry_t wr_dat_i,
    output logic      rd_vld_o,
    input  logic      rd_rdy_i,
    output rx_entry_t rd_dat_o
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        empty;
    logic        full;
    logic        do_wr;
    logic        do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd    = !empty && rd_rdy_i;
    // A pop on the same edge frees the slot, so a full FIFO can still take a write.
    assign wr_rdy_o = !full || do_rd;
    assign do_wr    = wr_vld_i && wr_rdy_o;
    assign rd_vld_o = !empty;
    // Head is forced to zero when empty so the outputs are clean out of reset.
    assign rd_dat_o = empty ? rx_entry_t'('0) : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: it is only read while non-empty.
    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end

endmodule

// File: rtl/router_port_rx.sv
// Purpose: deserialise one router output port (LSB-first) into sop/eop-tagged bytes.
// Latency: byte whose 8th bit is sampled at edge N is on out_* right after edge N (FIFO empty).
// Backpressure: out_ready stalls the byte FIFO; bytes arriving while full are dropped and ovf sticks.
// Ports: clock, reset_n (async active-low), rx (router_port_rx_if.slave: serial in, byte stream out,
//        pkt_err pulse, sticky ovf, pkt_len).
// Option: define ROUTER_PORT_RX_LEN_EN to enable the saturating packet-length counter on pkt_len;
//         otherwise pkt_len is tied to zero.
module router_port_rx
    import router_port_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    router_port_rx_if.slave rx
);

    rx_state_e         state_q;
    logic [2:0]        bit_cnt_q;
    logic [BYTE_W-1:0] shreg_q;
    logic [BYTE_W-1:0] shreg_d;
    logic              sop_pend_q;
    logic              pkt_err_q;
    logic              ovf_q;
    logic              bit_vld;
    logic              byte_done;
    logic              push_rdy;
    rx_entry_t         push_dat;
    rx_entry_t         head;

    assign bit_vld   = !rx.valido_n;
    assign byte_done = (state_q == RECV) && bit_vld && (bit_cnt_q == 3'd7);

    // Shift register with the current bit merged in; bit 7 goes straight into
    // the pushed byte on the completing edge.
    always_comb begin
        shreg_d            = shreg_q;
        shreg_d[bit_cnt_q] = rx.dout;
    end

    // frameo_n high on the completing edge marks the last byte of the packet.
    assign push_dat = {shreg_d, sop_pend_q, rx.frameo_n};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= '0;
            sop_pend_q <= 1'b0;
            pkt_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            pkt_err_q <= 1'b0;
            if (byte_done && !push_rdy) ovf_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (!rx.frameo_n) begin
                        state_q    <= RECV;
                        sop_pend_q <= 1'b1;
                        if (bit_vld) begin
                            shreg_q   <= shreg_d;
                            bit_cnt_q <= 3'd1;
                        end
                    end
                end
                RECV: begin
                    if (bit_vld) begin
                        shreg_q   <= shreg_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    if (byte_done) sop_pend_q <= 1'b0;
                    if (rx.frameo_n) begin
                        // Any end that does not complete a byte is malformed: either a
                        // partial byte is thrown away or the last byte went out without eop.
                        state_q   <= IDLE;
                        bit_cnt_q <= 3'd0;
                        if (!byte_done) pkt_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    router_port_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_vld_i (byte_done),
        .wr_rdy_o (push_rdy),
        .wr_dat_i (push_dat),
        .rd_vld_o (rx.out_valid),
        .rd_rdy_i (rx.out_ready),
        .rd_dat_o (head)
    );

    assign rx.out_data = head.data;
    assign rx.out_sop  = head.sop;
    assign rx.out_eop  = head.eop;
    assign rx.pkt_err  = pkt_err_q;
    assign rx.ovf      = ovf_q;

`ifdef ROUTER_PORT_RX_LEN_EN
    logic [LEN_W-1:0] len_cnt_q;
    logic [LEN_W-1:0] len_cnt_d;
    logic [LEN_W-1:0] pkt_len_q;

    // Saturating increment; bytes dropped on overflow still count.
    assign len_cnt_d = (&len_cnt_q) ? len_cnt_q : len_cnt_q + LEN_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_cnt_q <= '0;
            pkt_len_q <= '0;
        end else if (state_q == IDLE) begin
            len_cnt_q <= '0;
        end else if (byte_done) begin
            if (rx.frameo_n) begin
                pkt_len_q <= len_cnt_d;
                len_cnt_q <= '0;
            end else begin
                len_cnt_q <= len_cnt_d;
            end
        end
    end

    assign rx.pkt_len = pkt_len_q;
`else
    assign rx.pkt_len = {LEN_W{1'b0}};
`endif

endmodule

// File: tb/tb_router_port_rx.sv
module tb_router_port_rx;
    import router_port_rx_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    router_port_rx_if #(.LEN_W(16)) rx_if ();

    router_port_rx #(
        .FIFO_DEPTH (4),
        .LEN_W      (16)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .rx      (rx_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Expected pkt_len: the count when the length counter is built in, else zero.
    function automatic logic [31:0] plen(input int n);
        plen = 32'(n);
`ifndef ROUTER_PORT_RX_LEN_EN
        plen = 32'd0;
`endif
    endfunction

    // Drive one cycle of serial inputs; returns 1 time unit after the sampling edge.
    task automatic tick(input logic v_n, input logic f_n, input logic d);
        rx_if.valido_n = v_n;
        rx_if.frameo_n = f_n;
        rx_if.dout     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(1'b1, 1'b1, 1'b0);
    endtask

    // LSB-first byte; two gap cycles before bit gap_at; out_ready pulsed with bit 7 if rdy7.
    task automatic send_byte(input logic [7:0] b, input logic last, input int gap_at, input logic rdy7);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                tick(1'b1, 1'b0, 1'b0);
                tick(1'b1, 1'b0, 1'b0);
            end
            rx_if.out_ready = rdy7 && (i == 7);
            tick(1'b0, last && (i == 7), b[i]);
        end
        rx_if.out_ready = 1'b0;
    endtask

    task automatic head_check(input string tag, input logic [7:0] d, input logic s, input logic e);
        check({tag, ".vld"}, 32'(rx_if.out_valid), 32'd1);
        check({tag, ".dat"}, 32'(rx_if.out_data),  32'(d));
        check({tag, ".sop"}, 32'(rx_if.out_sop),   32'(s));
        check({tag, ".eop"}, 32'(rx_if.out_eop),   32'(e));
    endtask

    task automatic pop();
        rx_if.out_ready = 1'b1;
        idle();
        rx_if.out_ready = 1'b0;
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, ".vld"}, 32'(rx_if.out_valid), 32'd0);
        check({tag, ".dat"}, 32'(rx_if.out_data),  32'd0);
        check({tag, ".sop"}, 32'(rx_if.out_sop),   32'd0);
        check({tag, ".eop"}, 32'(rx_if.out_eop),   32'd0);
        check({tag, ".err"}, 32'(rx_if.pkt_err),   32'd0);
        check({tag, ".ovf"}, 32'(rx_if.ovf),       32'd0);
        check({tag, ".len"}, 32'(rx_if.pkt_len),   32'd0);
    endtask

    initial begin
        logic [7:0] partial;
        rx_if.dout      = 1'b0;
        rx_if.valido_n  = 1'b1;
        rx_if.frameo_n  = 1'b1;
        rx_if.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        outputs_zero("rst");
        rst_n = 1'b1;
        idle();

        // Single byte 0xA5 with eop on bit 7
        send_byte(8'hA5, 1'b1, -1, 1'b0);
        check("t1.err", 32'(rx_if.pkt_err), 32'd0);
        head_check("t1", 8'hA5, 1'b1, 1'b1);
        check("t1.len", 32'(rx_if.pkt_len), plen(1));
        pop();
        check("t1.empty", 32'(rx_if.out_valid), 32'd0);

        // Three bytes with mid-byte gaps
        send_byte(8'h01, 1'b0, 3, 1'b0);
        send_byte(8'h02, 1'b0, 5, 1'b0);
        send_byte(8'h03, 1'b1, 2, 1'b0);
        check("t2.err", 32'(rx_if.pkt_err), 32'd0);
        check("t2.len", 32'(rx_if.pkt_len), plen(3));
        head_check("t2.b0", 8'h01, 1'b1, 1'b0);
        pop();
        head_check("t2.b1", 8'h02, 1'b0, 1'b0);
        pop();
        head_check("t2.b2", 8'h03, 1'b0, 1'b1);
        pop();
        check("t2.empty", 32'(rx_if.out_valid), 32'd0);

        // Malformed end after 5 bits, then a clean packet
        partial = 8'h15;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, partial[i]);
        tick(1'b1, 1'b1, 1'b0);
        check("t3.err_hi", 32'(rx_if.pkt_err), 32'd1);
        check("t3.nopush", 32'(rx_if.out_valid), 32'd0);
        check("t3.len_held", 32'(rx_if.pkt_len), plen(3));
        idle();
        check("t3.err_lo", 32'(rx_if.pkt_err), 32'd0);
        send_byte(8'h3C, 1'b1, -1, 1'b0);
        check("t3.err2", 32'(rx_if.pkt_err), 32'd0);
        head_check("t3.b", 8'h3C, 1'b1, 1'b1);
        check("t3.len", 32'(rx_if.pkt_len), plen(1));
        pop();

        // Full FIFO with a pop on the same edge the 5th byte completes
        for (int k = 0; k < 4; k++) send_byte(8'(8'h21 + k), 1'b0, -1, 1'b0);
        head_check("t5.full", 8'h21, 1'b1, 1'b0);
        send_byte(8'h25, 1'b1, -1, 1'b1);
        check("t5.ovf", 32'(rx_if.ovf), 32'd0);
        check("t5.len", 32'(rx_if.pkt_len), plen(5));
        for (int k = 0; k < 4; k++) begin
            head_check($sformatf("t5.b%0d", k), 8'(8'h22 + k), 1'b0, k == 3);
            pop();
        end
        check("t5.empty", 32'(rx_if.out_valid), 32'd0);

        // Overflow: six bytes into a four-entry FIFO with no consumer
        for (int k = 0; k < 6; k++) begin
            send_byte(8'(8'h10 + k), k == 5, -1, 1'b0);
            if (k == 3) check("t4.ovf_pre", 32'(rx_if.ovf), 32'd0);
            if (k == 4) check("t4.ovf_set", 32'(rx_if.ovf), 32'd1);
        end
        check("t4.err", 32'(rx_if.pkt_err), 32'd0);
        check("t4.len", 32'(rx_if.pkt_len), plen(6));
        for (int k = 0; k < 4; k++) begin
            head_check($sformatf("t4.b%0d", k), 8'(8'h10 + k), k == 0, 1'b0);
            pop();
        end
        check("t4.empty", 32'(rx_if.out_valid), 32'd0);
        check("t4.ovf_sticky", 32'(rx_if.ovf), 32'd1);

        // Reset in the middle of a packet
        send_byte(8'h5A, 1'b0, -1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        check("t6.pre_vld", 32'(rx_if.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        outputs_zero("t6.rst");
        rx_if.valido_n = 1'b1;
        rx_if.frameo_n = 1'b1;
        rx_if.dout     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        check("t6.err", 32'(rx_if.pkt_err), 32'd0);
        check("t6.vld", 32'(rx_if.out_valid), 32'd0);
        send_byte(8'hFF, 1'b1, -1, 1'b0);
        head_check("t6.b", 8'hFF, 1'b1, 1'b1);
        check("t6.len", 32'(rx_if.pkt_len), plen(1));
        pop();
        check("t6.empty", 32'(rx_if.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_port_rx.md
# router_port_rx

Serial-to-byte receiver attached to one router output port. It samples the router's `dout`/`valido_n`/`frameo_n` serial stream, assembles LSB-first bytes, and tags each byte with start/end-of-packet flags. It buffers bytes in a small FIFO and presents them on a valid/ready byte stream to the monitor/scoreboard side. One instance sits per output port (16 in the full bench).

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO entries; power of two, ≥2.
- `LEN_W`, default 16: width of the packet-length counter.

Ports:
- `clock` in 1: sole clock; all state updates on posedge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `dout` in 1: serial data bit from router output port.
- `valido_n` in 1: active-low bit-valid.
- `frameo_n` in 1: active-low frame; high on the cycle carrying the last bit.
- `out_data` out 8: assembled byte at FIFO head.
- `out_sop` out 1: head byte is first of packet.
- `out_eop` out 1: head byte is last of packet.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts head when `out_valid & out_ready`.
- `pkt_err` out 1: one-cycle pulse on malformed frame end.
- `ovf` out 1: sticky; a byte was dropped because the FIFO was full.
- `pkt_len` out LEN_W: byte count of last completed packet (only with macro).

## Operation
- State machine, states IDLE and RECV.
- **IDLE**
  - On a posedge with `frameo_n=0`, move to RECV.
  - If `valido_n=0` on that same edge, capture the bit as bit 0.
  - The first byte completed after entering RECV carries sop=1.
- **RECV**, bit sampled when `valido_n=0`
  - Shift into `shreg[bit_cnt]`; `bit_cnt` is 3-bit and wraps 7→0.
  - On `bit_cnt==7`, the byte is complete and pushed as {data, sop, eop}.
  - eop=1 iff `frameo_n=1` on that edge.
- **Frame end**
  - Frame ends when `frameo_n=1` is sampled in RECV; the state returns to IDLE.
  - If the ending sample has `valido_n=0` and completes a byte: normal eop.
  - Otherwise (partial byte, or `valido_n=1` with `bit_cnt!=0`): discard the partial byte, no eop byte, pulse `pkt_err`.
  - Ending with `valido_n=1` and `bit_cnt==0` also pulses `pkt_err`, because the last byte was pushed without eop.
- **Gaps**: `valido_n=1` with `frameo_n=0` in RECV is a gap; state is held, nothing shifts.
- **Push on full**: the byte is dropped, `ovf` is set, and reception continues. If the dropped byte carried eop, the packet still ends normally.
- **Simultaneous push and pop**: allowed when full; the pop frees the slot, so no overflow occurs.
- **Reset values**: state IDLE, `bit_cnt` 0, FIFO empty, `out_valid` 0, `out_data`/`out_sop`/`out_eop` 0, `pkt_err` 0, `ovf` 0, `pkt_len` 0.
- **Reset mid-packet**: the partial packet is discarded entirely and no `pkt_err` is raised.

## Timing
- Inputs are sampled on posedge `clock`; the upstream clocking block applies output skew, so no extra synchronisers.
- **Latency**: the byte whose 8th bit is sampled at edge N appears on `out_*` after edge N (registered FIFO write, fall-through head) when the FIFO was empty.
- `pkt_err` is high for exactly the cycle following the edge that sampled the malformed end.
- `ovf` clears only on reset.
- Back-to-back packets are supported: a new `frameo_n=0` is accepted on the edge directly after the frame-end edge.

## Configuration
- Macro `ROUTER_PORT_RX_LEN_EN`.
- **Defined**:
  - A LEN_W-bit counter increments per completed byte in a packet, including bytes dropped by overflow.
  - `pkt_len` loads the count on the eop edge and holds it until the next eop.
  - The counter saturates at all-ones.
- **Undefined**: the counter is absent and `pkt_len` is tied to 0.

## Structure
- Package `router_port_rx_pkg`:
  - `BYTE_W=8`
  - enum `rx_state_e` {IDLE, RECV}
  - packed struct `rx_entry_t` {data[7:0], sop, eop}
- Sub-module `router_port_rx_fifo`: synchronous FIFO of `rx_entry_t`, FIFO_DEPTH entries.
  - Pointers are log2(FIFO_DEPTH)+1 bits, with full/empty taken from the MSB comparison.
  - Same async active-low reset.

## Test plan
- **Single byte**: packet 0xA5, 8 bits with `valido_n=0` and `frameo_n` high on bit 7 → one byte 0xA5 with sop=1, eop=1, `pkt_err` 0, `pkt_len`=1.
- **Gaps**: 3-byte packet 0x01,0x02,0x03 with 2-cycle `valido_n` gaps mid-byte → bytes in order; sop only on 0x01, eop only on 0x03.
- **Malformed end**: `frameo_n` rises after 5 bits → no byte pushed, `pkt_err` pulses once, next packet 0x3C is received cleanly with sop=1.
- **Overflow**: `out_ready=0` and a 6-byte packet with FIFO_DEPTH=4 → first 4 bytes retained, `ovf`=1; on draining, out_eop is never seen; `pkt_len`=6.
- **Full push/pop**: FIFO full, `out_ready=1` on the same edge a 5th byte completes → no overflow, byte order intact.
- **Reset mid-packet**: assert `reset_n` low mid-byte → all outputs 0 immediately; the subsequent packet 0xFF decodes correctly.
